// File: rtl/sprite_loader.sv
// Sprite RAM writer: turns a row-major valid/ready pixel stream into registered {row, col} writes.
// Optional build macro SPRITE_LOADER_COLOR_KEY_EN suppresses writes of the KEY (transparent) colour.
module sprite_loader #(
    parameter int unsigned   DW        = 8,
    parameter int unsigned   SIDE_LOG2 = 6,
    parameter logic [DW-1:0] KEY       = 8'hE3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DW-1:0]          s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   we,
    output logic [2*SIDE_LOG2-1:0] waddr,
    output logic [DW-1:0]          wdata,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                   state_q, state_d;
    logic [SIDE_LOG2-1:0]     col_q, row_q;
    logic                     we_q, done_q;
    logic [2*SIDE_LOG2-1:0]   waddr_q;
    logic [DW-1:0]            wdata_q;
    logic                     accept;
    logic                     last;
    logic                     write_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (accept && last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready = (state_q == StLoad) && !abort;
        accept  = s_ready && s_valid;
        last    = (&col_q) && (&row_q);
        // done_q extends busy through the cycle after DONE so busy falls two edges after the last accept
        busy    = (state_q != StIdle) || done_q;
    end

`ifdef SPRITE_LOADER_COLOR_KEY_EN
    assign write_en = accept && (s_data != KEY);
`else
    logic unused_key;
    assign unused_key = ^KEY;
    assign write_en   = accept;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= write_en;
            done_q <= (state_q == StDone);
            if ((state_q == StIdle) && start) begin
                col_q <= '0;
                row_q <= '0;
            end else if (accept) begin
                // address is the pre-increment position of the accepted word
                waddr_q <= {row_q, col_q};
                wdata_q <= s_data;
                col_q   <= col_q + SIDE_LOG2'(1);
                if (&col_q) begin
                    row_q <= row_q + SIDE_LOG2'(1);
                end
            end
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: directed vector table plus full-sprite load sequences.
// Honours SPRITE_LOADER_COLOR_KEY_EN so the same bench checks either build.
module tb_sprite_loader;

`ifdef SPRITE_LOADER_COLOR_KEY_EN
    localparam bit KeyEn = 1'b1;
`else
    localparam bit KeyEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, abort, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, we, busy, done;
    logic [11:0] waddr;
    logic [7:0]  wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_loader dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic        st;
        logic        ab;
        logic        v;
        logic [7:0]  d;
        logic        exp_ready;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[11];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full-sprite load; optionally with random s_valid gaps, alternating key data, an abort or a reset.
    task automatic load(input bit gaps, input bit alt, input int abort_at, input int reset_at);
        int         acc = 0;
        int         writes = 0;
        int         cyc = 0;
        int         exp_writes;
        logic       v;
        logic [7:0] d;
        logic       exp_we;
        string      nm;

        abort   = 1'b0;
        s_valid = 1'b0;
        start   = 1'b1;
        #1;
        chk1("idle_ready", s_ready, 1'b0);
        tick();
        start = 1'b0;
        chk1("load_busy", busy, 1'b1);

        while (acc < 4096 && cyc < 20000) begin
            cyc++;
            v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            d = alt ? (acc[0] ? 8'h12 : 8'hE3) : acc[7:0];
            if (!alt && acc == 63) d = 8'h55;
            abort   = (acc == abort_at);
            rst_n   = !(acc == reset_at);
            s_valid = v;
            s_data  = d;
            #1;
            chk1("load_ready", s_ready, !abort);
            tick();

            if (!rst_n) begin
                chk1("reset_we", we, 1'b0);
                chkn("reset_waddr", 32'(waddr), 32'h0);
                chkn("reset_wdata", 32'(wdata), 32'h0);
                chk1("reset_done", done, 1'b0);
                chk1("reset_busy", busy, 1'b0);
                chk1("reset_ready", s_ready, 1'b0);
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk1("post_reset_we", we, 1'b0);
                    chk1("post_reset_ready", s_ready, 1'b0);
                    chk1("post_reset_busy", busy, 1'b0);
                end
                s_valid = 1'b0;
                return;
            end

            if (abort) begin
                chk1("abort_we", we, 1'b0);
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_done", done, 1'b0);
                abort = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk1("post_abort_we", we, 1'b0);
                    chk1("post_abort_done", done, 1'b0);
                    chk1("post_abort_ready", s_ready, 1'b0);
                end
                s_valid = 1'b0;
                return;
            end

            exp_we = v && !(KeyEn && d == 8'hE3);
            chk1("load_we", we, exp_we);
            if (v) begin
                nm = (acc == 63 || acc == 64) ? "row_wrap_addr" : "load_waddr";
                chkn(nm, 32'(waddr), 32'(acc[11:0]));
                chkn("load_wdata", 32'(wdata), 32'(d));
                acc++;
            end
            if (we) writes++;
            if (acc < 4096) chk1("load_no_done", done, 1'b0);
        end

        chkn("load_accepts", 32'(acc), 32'd4096);
        if (alt) exp_writes = KeyEn ? 2048 : 4096;
        else     exp_writes = KeyEn ? 4080 : 4096;
        chkn("load_writes", 32'(writes), 32'(exp_writes));

        // After edge N (last accept): in DONE
        chk1("tail_n_done", done, 1'b0);
        chk1("tail_n_busy", busy, 1'b1);
        chk1("tail_n_ready", s_ready, 1'b0);
        tick();
        chk1("tail_n1_we", we, 1'b0);
        chk1("tail_n1_done", done, 1'b1);
        chk1("tail_n1_busy", busy, 1'b1);
        chk1("tail_n1_ready", s_ready, 1'b0);
        s_valid = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk1("tail_n2_done", done, 1'b0);
        chk1("restart_busy", busy, 1'b1);
        chk1("restart_ready", s_ready, 1'b1);
        abort = 1'b1;
        #1;
        chk1("restart_abort_ready", s_ready, 1'b0);
        tick();
        abort = 1'b0;
        chk1("restart_abort_busy", busy, 1'b0);
        chk1("restart_abort_we", we, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;

        //          st    ab    v     d      rdy   we    addr     done  busy
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 12'h001, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 12'h002, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};

        tick();
        tick();
        chk1("rst_we", we, 1'b0);
        chkn("rst_waddr", 32'(waddr), 32'h0);
        chkn("rst_wdata", 32'(wdata), 32'h0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            start   = vecs[i].st;
            abort   = vecs[i].ab;
            s_valid = vecs[i].v;
            s_data  = vecs[i].d;
            #1;
            chk1($sformatf("vec%0d_ready", i), s_ready, vecs[i].exp_ready);
            tick();
            chk1($sformatf("vec%0d_we", i), we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chkn($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(vecs[i].exp_addr));
                chkn($sformatf("vec%0d_wdata", i), 32'(wdata), 32'(vecs[i].d));
            end
            chk1($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            chk1($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        tick();

        load(1'b0, 1'b0, -1, -1);
        load(1'b1, 1'b0, -1, -1);
        load(1'b0, 1'b0, 100, -1);
        load(1'b0, 1'b0, -1, 2000);
        load(1'b0, 1'b1, -1, -1);
        load(1'b0, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Writer side of the sprite memory. The pixel address generator reads this memory at {row[5:0], col[5:0]}; this block fills it.
- Accepts a row-major pixel stream over a valid/ready handshake and produces sprite-RAM write strobes, addresses and data in the same {row, col} packing.
- Sits between the host or UART loader path and the write port of the sprite RAM.

Parameters:
- DW, 8, pixel data width (RGB332 default).
- SIDE_LOG2, 6, log2 of the sprite side length. Sprite is 2^SIDE_LOG2 square; address width is 2*SIDE_LOG2 (12 by default).
- KEY, 8'hE3, transparent colour key. Used only when COLOR_KEY_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a sprite load. Sampled only in IDLE.
- abort  in  1  cancel a load in progress.
- s_data  in  DW  pixel word.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a word this cycle.
- we  out  1  sprite RAM write enable, registered.
- waddr  out  2*SIDE_LOG2  write address {row, col}, registered.
- wdata  out  DW  write data, registered.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse when a full sprite has been accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, col=0, row=0.
  - we=0, waddr=0, wdata=0, done=0, busy=0.
  - Reset overrides start and abort and takes effect mid-load. No further we pulses after the reset edge.
- Handshake:
  - s_ready = (state==LOAD) && !abort. This is combinational from the state and abort only, never from s_valid.
  - A word is accepted on a clk edge with s_valid && s_ready.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: s_ready=0. start=1 -> LOAD with col=0, row=0.
  - LOAD: on each accepted word, col increments.
    - col==2^SIDE_LOG2-1 wraps col to 0 and increments row.
    - The accepted word with col==row==all-ones -> DONE.
  - LOAD, abort=1 -> IDLE. The word in that cycle is not accepted and done is not asserted. Words already written stay in RAM.
  - DONE: lasts one cycle with done=1 (registered), s_ready=0, then -> IDLE.
  - start in LOAD or DONE is ignored.
- Write latency: one cycle.
  - The accept edge registers we=1, waddr={row,col} (pre-increment values) and wdata=s_data.
  - we is 0 in every cycle following a non-accept edge.
- Throughput: one word per clock with s_valid held high. A full 64x64 sprite is 4096 accepts.
- Arithmetic: col and row are SIDE_LOG2-bit unsigned and wrap naturally. Address = {row, col}, no adder.
- Timing of the final accept:
  - Last accept at edge N: we/waddr=all-ones visible after edge N.
  - done=1 after edge N+1. busy falls after edge N+2.
  - A start asserted in the IDLE cycle after DONE starts a new load.
- s_valid while not in LOAD: the word is ignored and no state changes.

Optional Feature:
- Macro: SPRITE_LOADER_COLOR_KEY_EN.
- Defined: an accepted word equal to KEY advances col/row exactly as normal, but the write is suppressed.
  - we stays 0 for that word; waddr and wdata still update.
  - This preserves the prior RAM contents behind transparent pixels.
  - done timing is unchanged.
- Undefined: KEY is unused and every accepted word writes.

Test Plan:
- Full load, s_valid=1 continuously, s_data=addr[7:0] -> 4096 we pulses; waddr runs 0x000..0xFFF in order; done one cycle after the 0xFFF write; busy low the cycle after done.
- Row wrap: 64th word accepted with s_data=8'h55 -> waddr=0x03F, next word -> waddr=0x040 (row=1, col=0).
- Backpressure gaps: s_valid toggles 1,0,0,1 pseudo-randomly -> we only on accept edges; address sequence is gap-free; still exactly 4096 writes before done.
- Abort after 100 accepts, s_valid held 1 -> no accept in the abort cycle; we=0 thereafter; done never pulses; the next start restarts at waddr=0x000.
- rst_n=0 for one cycle after word 2000 -> all outputs 0 the next cycle; state IDLE; s_ready=0 until start.
- With SPRITE_LOADER_COLOR_KEY_EN, a stream alternating 8'hE3 and 8'h12 -> we only on even-count (8'h12) words; waddr still increments every accept; done after 4096 accepts.
